// File: rtl/video_timing.sv
// Free-running raster timing generator: pixel/line counters drive renderer
// coordinates, and sync/blank decodes are registered to match renderer latency.
module video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_in,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pixel_out,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS        = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS        = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_reg, h_cnt_next;
  logic [11:0] v_cnt_reg, v_cnt_next;
  logic        hsync_reg, vsync_reg, video_on_reg, frame_tick_reg;
  logic        hsync_next, vsync_next, video_on_next, frame_tick_next;

  always_comb begin
    h_cnt_next = h_cnt_reg + 12'd1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = 12'd0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
    end
  end

  // Decodes of the current count; registered so they line up with renderer output.
  always_comb begin
    hsync_next      = ((h_cnt_reg >= H_SYNC_START) && (h_cnt_reg < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_next      = ((v_cnt_reg >= V_SYNC_START) && (v_cnt_reg < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_next   = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    frame_tick_next = (h_cnt_reg == 12'd0) && (v_cnt_reg == V_VIS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_reg      <= 12'd0;
      v_cnt_reg      <= 12'd0;
      hsync_reg      <= ~SYNC_POL;
      vsync_reg      <= ~SYNC_POL;
      video_on_reg   <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      h_cnt_reg      <= h_cnt_next;
      v_cnt_reg      <= v_cnt_next;
      hsync_reg      <= hsync_next;
      vsync_reg      <= vsync_next;
      video_on_reg   <= video_on_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign x          = h_cnt_reg;
  assign y          = v_cnt_reg;
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign video_on   = video_on_reg;
  assign frame_tick = frame_tick_reg;
  // Renderer output is already one clock late, so it pairs with the registered blank.
  assign pixel_out  = pixel_in & video_on_reg;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: small-raster instance checked cycle-by-cycle against a
// scoreboard model, plus a default-parameter instance for VGA line timing.
module tb_video_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small raster: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), sync active high.
  logic        rst_s, pin_s;
  logic [11:0] x_s, y_s;
  logic        hs_s, vs_s, von_s, pout_s, ft_s;

  logic        rst_d, pin_d;
  logic [11:0] x_d, y_d;
  logic        hs_d, vs_d, von_d, pout_d, ft_d;

  video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pixel_in(pin_s),
    .x(x_s), .y(y_s), .hsync(hs_s), .vsync(vs_s),
    .video_on(von_s), .pixel_out(pout_s), .frame_tick(ft_s)
  );

  video_timing dut_d (
    .clk(clk), .rst(rst_d), .pixel_in(pin_d),
    .x(x_d), .y(y_d), .hsync(hs_d), .vsync(vs_d),
    .video_on(von_d), .pixel_out(pout_d), .frame_tick(ft_d)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        pout;
    logic        ft;
  } obs_t;

  obs_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   mh, mv;

  // Reference raster for the small instance: outputs after the next edge.
  function automatic obs_t model_step(input logic pin);
    obs_t e;
    e.hs  = (mh >= 10 && mh < 12);
    e.vs  = (mv == 5);
    e.von = (mh < 8) && (mv < 4);
    e.ft  = (mh == 0) && (mv == 4);
    if (mh == 13) begin
      mh = 0;
      mv = (mv == 6) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    e.x    = 12'(mh);
    e.y    = 12'(mv);
    e.pout = pin & e.von;
    return e;
  endfunction

  function automatic obs_t sample_s();
    obs_t a;
    a = {x_s, y_s, hs_s, vs_s, von_s, pout_s, ft_s};
    return a;
  endfunction

  task automatic test_reset();
    obs_t a, e;
    rst_s = 1'b1; rst_d = 1'b1; pin_s = 1'b1; pin_d = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = sample_s();
    e = '{x: 12'd0, y: 12'd0, hs: 1'b0, vs: 1'b0, von: 1'b0, pout: 1'b0, ft: 1'b0};
    total++;
    if (a !== e) $display("FAIL reset_small got=%h want=%h", a, e);
    else passed++;
    total++;
    if ({x_d, y_d, hs_d, vs_d, von_d, pout_d, ft_d} !== {12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_default got=%h want=%h",
               {x_d, y_d, hs_d, vs_d, von_d, pout_d, ft_d}, {12'd0, 12'd0, 5'b11000});
    else passed++;
    $display("reset: small=%h default x=%0d y=%0d hs=%b vs=%b", a, x_d, y_d, hs_d, vs_d);
  endtask

  task automatic test_small_frames();
    obs_t a, e;
    int ticks = 0;
    mh = 0; mv = 0;
    rst_s = 1'b0;
    for (int k = 1; k <= 2 * 98; k++) begin
      pin_s = 1'($urandom);
      sb.push_back(model_step(pin_s));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      a = sample_s();
      if (a.ft) ticks++;
      total++;
      if (a !== e) $display("FAIL small_cycle%0d got=%h want=%h", k, a, e);
      else passed++;
      $display("small cycle %0d: x=%0d y=%0d hs=%b vs=%b von=%b pout=%b ft=%b",
               k, a.x, a.y, a.hs, a.vs, a.von, a.pout, a.ft);
    end
    total++;
    if (ticks !== 2) $display("FAIL small_tick_count got=%0d want=2", ticks);
    else passed++;
  endtask

  task automatic test_midframe_reset();
    obs_t a, e;
    int found = 0;
    int first_tick = -1;
    int ticks = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      pin_s = 1'b1;
      sb.push_back(model_step(pin_s));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (x_s == 12'd5 && y_s == 12'd2) found = 1;
    end
    total++;
    if (found == 0) $display("FAIL midreset_seek got=timeout want=x5y2");
    else passed++;
    #1;
    rst_s = 1'b1;
    #1;
    a = sample_s();
    e = '{x: 12'd0, y: 12'd0, hs: 1'b0, vs: 1'b0, von: 1'b0, pout: 1'b0, ft: 1'b0};
    total++;
    if (a !== e) $display("FAIL midreset_async got=%h want=%h", a, e);
    else passed++;
    $display("midframe reset: outputs=%h", a);
    @(posedge clk);
    @(negedge clk);
    rst_s = 1'b0;
    mh = 0; mv = 0;
    for (int k = 1; k <= 70; k++) begin
      pin_s = 1'($urandom);
      sb.push_back(model_step(pin_s));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      a = sample_s();
      if (a.ft) begin
        ticks++;
        if (first_tick < 0) first_tick = k;
      end
      total++;
      if (a !== e) $display("FAIL post_reset_cycle%0d got=%h want=%h", k, a, e);
      else passed++;
      $display("post-reset cycle %0d: x=%0d y=%0d ft=%b", k, a.x, a.y, a.ft);
    end
    total++;
    if (first_tick !== 57 || ticks !== 1)
      $display("FAIL post_reset_tick got=cycle%0d/count%0d want=cycle57/count1", first_tick, ticks);
    else passed++;
  endtask

  task automatic test_default_line();
    int first_hs = -1;
    int hs_low_line0 = 0;
    int pout_line0 = 0;
    int vs_low = 0;
    int ft_cnt = 0;
    pin_d = 1'b1;
    @(negedge clk);
    rst_d = 1'b0;
    total++;
    if (x_d !== 12'd0) $display("FAIL default_x0 got=%0d want=0", x_d);
    else passed++;
    for (int k = 1; k <= 1700; k++) begin
      @(posedge clk);
      #1;
      if (hs_d == 1'b0 && first_hs < 0) first_hs = k;
      if (k <= 800 && hs_d == 1'b0) hs_low_line0++;
      if (k <= 800 && pout_d == 1'b1) pout_line0++;
      if (vs_d == 1'b0) vs_low++;
      if (ft_d) ft_cnt++;
      if (k <= 2 || (k >= 799 && k <= 800)) begin
        total++;
        if (x_d !== 12'(k % 800) || y_d !== 12'(k / 800))
          $display("FAIL default_count_k%0d got=x%0d,y%0d want=x%0d,y%0d", k, x_d, y_d, k % 800, k / 800);
        else passed++;
        $display("default cycle %0d: x=%0d y=%0d", k, x_d, y_d);
      end
    end
    total++;
    if (first_hs !== 657) $display("FAIL default_hsync_first got=%0d want=657", first_hs);
    else passed++;
    total++;
    if (hs_low_line0 !== 96) $display("FAIL default_hsync_width got=%0d want=96", hs_low_line0);
    else passed++;
    total++;
    if (pout_line0 !== 640) $display("FAIL default_pixels_line0 got=%0d want=640", pout_line0);
    else passed++;
    total++;
    if (vs_low !== 0 || ft_cnt !== 0)
      $display("FAIL default_no_vblank got=vs%0d,ft%0d want=vs0,ft0", vs_low, ft_cnt);
    else passed++;
    $display("default line: first_hs=%0d hs_low=%0d pixels=%0d", first_hs, hs_low_line0, pout_line0);
  endtask

  initial begin
    test_reset();
    test_small_frames();
    test_midframe_reset();
    test_default_line();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
